uart_rx_sampler: RTL and testbench

Serial-to-parallel UART receiver: samples the asynchronous `rx` line and delivers each received 8N1 byte on a parallel port with a one-cycle strobe. It sits behind the pad input of `uart_top` and is the receive end of the link whose transmit side sends LSB-first frames at 115200 baud from a 50 MHz clock. It provides start-bit glitch rejection, framing-error reporting and optional even parity.

---
 rtl/uart_rx_sampler.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 (optionally 8E1) UART receiver with mid-bit sampling and glitch rejection.
// Latency: 2-cycle input sync; result strobe is registered one cycle after the mid-stop-bit sample.
// Backpressure: none; each result is a one-cycle strobe and data_out holds the last good byte.
//
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   rx                    - asynchronous serial input, idles high
//   data_out[7:0]         - last byte received without error
//   data_ready            - one-cycle strobe when data_out updates
//   frame_err             - one-cycle strobe when the stop bit is sampled low
//   parity_err            - one-cycle strobe on even-parity mismatch (0 unless UART_RX_PARITY_EN)
//   busy                  - high whenever the receiver is not idle
// Optional feature: define UART_RX_PARITY_EN for a start + 8 data + even parity + stop frame.
module uart_rx_sampler #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [8:0] HALF_LAST = 9'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0] FULL_LAST = 9'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    , PARITY  = 3'd5
`endif
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       rdy_q, rdy_d;
  logic       ferr_q, ferr_d;
  logic       rx_s;
`ifdef UART_RX_PARITY_EN
  logic       perr_q, perr_d;
  logic       par_bad_q, par_bad_d;
`endif

  assign rx_s = sync2_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 9'd1;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    rdy_d     = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = (^shreg_q) ^ rx_s;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Leaving at mid-stop-bit lets a start bit follow with no idle gap.
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d = shreg_q;
              rdy_d  = 1'b1;
            end
`else
            data_d = shreg_q;
            rdy_d  = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line recovers so a break is not seen as frames.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q != IDLE);
    data_out   = data_q;
    data_ready = rdy_q;
    frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    parity_err = perr_q;
`else
    parity_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  localparam int BIT = 434;
`ifdef UART_RX_PARITY_EN
  localparam int LAT       = 4126 + BIT;
  localparam int FRAME_CYC = 11 * BIT;
`else
  localparam int LAT       = 4126;
  localparam int FRAME_CYC = 10 * BIT;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_ready, frame_err, parity_err, busy;

  uart_rx_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor
  int         rdy_cnt  = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         excl_cnt = 0;
  logic [7:0] rdy_vals[$];
  int         rdy_cycs[$];

  always @(negedge clk) begin
    if (data_ready) begin
      rdy_cnt++;
      rdy_vals.push_back(data_out);
      rdy_cycs.push_back(cyc);
    end
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (int'(data_ready) + int'(frame_err) + int'(parity_err) > 1) excl_cnt++;
  end

  int pass_cnt = 0;
  int total    = 0;
  int fall_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Holds rx at v for one bit time; starts and ends 1 time unit after a rising edge.
  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int extra_low);
    fall_cyc = cyc;
    hold_bit(1'b0);
    for (int b = 0; b < 8; b++) hold_bit(d[b]);
`ifdef UART_RX_PARITY_EN
    hold_bit(par);
`else
    if (par === 1'bx) $display("parity bit unused");
`endif
    hold_bit(stop);
    for (int k = 0; k < extra_low; k++) hold_bit(1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         extra_low;
    int         exp_rdy;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int r0, f0, p0, n0;
    logic [7:0] a5;

    vecs[0] = '{8'hA5, 1'b1, 0, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 2, 0, 1, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1, 0, 1, 0, 8'h5A};
    vecs[3] = '{8'hC3, 1'b1, 0, 1, 0, 8'hC3};
    vecs[4] = '{8'h01, 1'b0, 0, 0, 1, 8'hC3};
    vecs[5] = '{8'h80, 1'b1, 0, 1, 0, 8'h80};

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out",   32'(data_out),   32'h00);
    chk("reset_data_ready", 32'(data_ready), 32'h0);
    chk("reset_frame_err",  32'(frame_err),  32'h0);
    chk("reset_parity_err", 32'(parity_err), 32'h0);
    chk("reset_busy",       32'(busy),       32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_bit(1'b1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      r0 = rdy_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop, vecs[i].extra_low);
      if (vecs[i].extra_low > 0) begin
        @(negedge clk);
        chk($sformatf("v%0d_wait_idle_busy", i), 32'(busy), 32'h1);
        @(posedge clk); #1;
      end
      hold_bit(1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_ready_cnt", i), 32'(rdy_cnt - r0),   32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_ferr_cnt", i),  32'(ferr_cnt - f0),  32'(vecs[i].exp_ferr));
      chk($sformatf("v%0d_data_out", i),  32'(data_out),       32'(vecs[i].exp_dout));
      chk($sformatf("v%0d_busy_idle", i), 32'(busy),           32'h0);
      if (vecs[i].exp_rdy == 1)
        chk($sformatf("v%0d_latency", i), 32'(rdy_cycs[$] - fall_cyc), 32'(LAT));
      @(posedge clk); #1;
    end

    // Glitch rejection: 100-cycle low pulse
    r0 = rdy_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_high", 32'(busy), 32'h1);
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    while (busy && (cyc - fall_cyc) < 400) @(negedge clk);
    chk("glitch_busy_drop", 32'(busy), 32'h0);
    chk("glitch_drop_time", 32'((cyc - fall_cyc) <= 222), 32'h1);
    @(posedge clk); #1;
    hold_bit(1'b1);
    chk("glitch_no_strobe", 32'((rdy_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0)), 32'h0);
    chk("glitch_data_out",  32'(data_out), 32'h80);

    // Back-to-back frames, no idle gap
    r0 = rdy_cnt;
    n0 = rdy_cycs.size();
    send_frame(8'h00, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    send_frame(8'h81, 1'b0, 1'b1, 0);
    hold_bit(1'b1);
    chk("b2b_ready_cnt", 32'(rdy_cnt - r0), 32'h3);
    if (rdy_cycs.size() >= n0 + 3) begin
      chk("b2b_val0", 32'(rdy_vals[n0]),     32'h00);
      chk("b2b_val1", 32'(rdy_vals[n0 + 1]), 32'hFF);
      chk("b2b_val2", 32'(rdy_vals[n0 + 2]), 32'h81);
      chk("b2b_gap01", 32'(rdy_cycs[n0 + 1] - rdy_cycs[n0]),     32'(FRAME_CYC));
      chk("b2b_gap12", 32'(rdy_cycs[n0 + 2] - rdy_cycs[n0 + 1]), 32'(FRAME_CYC));
    end

    // Reset mid-frame after data bit 3
    r0 = rdy_cnt; f0 = ferr_cnt;
    a5 = 8'hA5;
    hold_bit(1'b0);
    for (int b = 0; b < 4; b++) hold_bit(a5[b]);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_data_out", 32'(data_out), 32'h00);
    chk("midrst_busy",     32'(busy),     32'h0);
    chk("midrst_flags",    32'({data_ready, frame_err, parity_err}), 32'h0);
    @(posedge clk); #1;
    hold_bit(1'b1);
    send_frame(8'h12, 1'b0, 1'b1, 0);
    hold_bit(1'b1);
    chk("midrst_ready_cnt", 32'(rdy_cnt - r0),  32'h1);
    chk("midrst_ferr_cnt",  32'(ferr_cnt - f0), 32'h0);
    chk("midrst_next_data", 32'(data_out),      32'h12);

`ifdef UART_RX_PARITY_EN
    // Even parity: good then bad parity bit on 8'hA5
    r0 = rdy_cnt; p0 = perr_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    hold_bit(1'b1);
    chk("par_ok_ready", 32'(rdy_cnt - r0),  32'h1);
    chk("par_ok_data",  32'(data_out),      32'hA5);
    r0 = rdy_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    hold_bit(1'b1);
    chk("par_bad_perr",  32'(perr_cnt - p0), 32'h1);
    chk("par_bad_ready", 32'(rdy_cnt - r0),  32'h0);
    chk("par_bad_data",  32'(data_out),      32'hA5);
`else
    chk("no_parity_err", 32'(perr_cnt), 32'h0);
`endif

    chk("strobes_exclusive", 32'(excl_cnt), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
